fixpoint_iter_ctrl: RTL and testbench

//  Sequencer that drives a combinational step/check evaluator (next-state + bug-flag cone) to a fixpoint.

---
 rtl/fixpoint_iter_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fixpoint_iter_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixpoint_iter_ctrl.sv
// Fixpoint sequencer: feeds a shared step/check evaluator from an initial state and iterates
// next-state until fixpoint, bug flag, iteration bound or abort, then reports a single result.
module fixpoint_iter_ctrl #(
  parameter int unsigned STATE_W  = 6,
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned CNT_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] init_state,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic [CNT_W-1:0]   iter_count,
  output logic [STATE_W-1:0] final_state,
  output logic               ev_req_valid,
  output logic [STATE_W-1:0] ev_req_state,
  input  logic               ev_req_ready,
  input  logic               ev_rsp_valid,
  input  logic [STATE_W-1:0] ev_rsp_next,
  input  logic               ev_rsp_bug
);

  localparam logic [1:0] ResFixpoint = 2'd0;
  localparam logic [1:0] ResBug      = 2'd1;
  localparam logic [1:0] ResTimeout  = 2'd2;
  localparam logic [1:0] ResAbort    = 2'd3;

  localparam logic [CNT_W-1:0] IterMax = CNT_W'(MAX_ITER);
  localparam logic [CNT_W-1:0] IterOne = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCheck,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [STATE_W-1:0] cur_q, cur_d;
  logic [STATE_W-1:0] nxt_q, nxt_d;
  logic               bug_q, bug_d;
  logic [CNT_W-1:0]   iter_q, iter_d;

  // end_run marks the single transition into StDone; end_result is its reason.
  logic               end_run;
  logic [1:0]         end_result;

  logic [1:0]         result_q;
  logic [CNT_W-1:0]   iter_count_q;
  logic [STATE_W-1:0] final_state_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    bug_d      = bug_q;
    iter_d     = iter_q;
    end_run    = 1'b0;
    end_result = ResAbort;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_d   = init_state;
          iter_d  = '0;
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (ev_req_ready) begin
          // Request is accepted even under abort; its response still has to be drained.
          state_d = abort ? StDrain : StWait;
        end else if (abort) begin
          state_d    = StDone;
          end_run    = 1'b1;
          end_result = ResAbort;
        end
      end

      StWait: begin
        if (abort) begin
          if (ev_rsp_valid) begin
            // Response arriving with abort is swallowed and not counted.
            state_d    = StDone;
            end_run    = 1'b1;
            end_result = ResAbort;
          end else begin
            state_d = StDrain;
          end
        end else if (ev_rsp_valid) begin
          nxt_d   = ev_rsp_next;
          bug_d   = ev_rsp_bug;
          iter_d  = iter_q + IterOne;
          state_d = StCheck;
        end
      end

      StCheck: begin
        if (bug_q) begin
          state_d    = StDone;
          end_run    = 1'b1;
          end_result = ResBug;
        end else if (nxt_q == cur_q) begin
          state_d    = StDone;
          end_run    = 1'b1;
          end_result = ResFixpoint;
        end else if (iter_q == IterMax) begin
          state_d    = StDone;
          end_run    = 1'b1;
          end_result = ResTimeout;
        end else if (abort) begin
          state_d    = StDone;
          end_run    = 1'b1;
          end_result = ResAbort;
        end else begin
          cur_d   = nxt_q;
          state_d = StIssue;
        end
      end

      StDrain: begin
        if (ev_rsp_valid) begin
          state_d    = StDone;
          end_run    = 1'b1;
          end_result = ResAbort;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= '0;
      nxt_q  <= '0;
      bug_q  <= 1'b0;
      iter_q <= '0;
    end else begin
      cur_q  <= cur_d;
      nxt_q  <= nxt_d;
      bug_q  <= bug_d;
      iter_q <= iter_d;
    end
  end

  // Result fields load on entry to StDone and hold until the next run ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q      <= ResFixpoint;
      iter_count_q  <= '0;
      final_state_q <= '0;
    end else if (end_run) begin
      result_q      <= end_result;
      iter_count_q  <= iter_d;
      final_state_q <= cur_q;
    end
  end

  // Outputs
  always_comb begin
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    ev_req_valid = (state_q == StIssue);
    ev_req_state = cur_q;
    result       = result_q;
    iter_count   = iter_count_q;
    final_state  = final_state_q;
  end

endmodule

// File: tb/tb_fixpoint_iter_ctrl.sv
// Bench for fixpoint_iter_ctrl: behavioural evaluator, table-driven directed runs, a mid-run
// reset sequence and randomized runs checked against a plain iteration model.
module tb_fixpoint_iter_ctrl;

  localparam int STATE_W  = 6;
  localparam int MAX_ITER = 64;
  localparam int CNT_W    = 7;

  localparam int RES_FIX = 0;
  localparam int RES_BUG = 1;
  localparam int RES_TMO = 2;
  localparam int RES_ABT = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [STATE_W-1:0] init_state = '0;
  logic               abort = 1'b0;
  logic               busy;
  logic               done;
  logic [1:0]         result;
  logic [CNT_W-1:0]   iter_count;
  logic [STATE_W-1:0] final_state;
  logic               ev_req_valid;
  logic [STATE_W-1:0] ev_req_state;
  logic               ev_req_ready = 1'b0;
  logic               ev_rsp_valid = 1'b0;
  logic [STATE_W-1:0] ev_rsp_next = '0;
  logic               ev_rsp_bug = 1'b0;

  fixpoint_iter_ctrl #(
    .STATE_W (STATE_W),
    .MAX_ITER(MAX_ITER),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .init_state  (init_state),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .iter_count  (iter_count),
    .final_state (final_state),
    .ev_req_valid(ev_req_valid),
    .ev_req_state(ev_req_state),
    .ev_req_ready(ev_req_ready),
    .ev_rsp_valid(ev_rsp_valid),
    .ev_rsp_next (ev_rsp_next),
    .ev_rsp_bug  (ev_rsp_bug)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural evaluator ----------------
  // mode 0: next=min(s+1,5); mode 1: next=s+1, bug at 3; mode 2: next=s+1; mode 3: tables
  int                 mode = 0;
  int                 stall_left = 0;
  int                 fixed_delay = 1;
  bit                 rand_ready = 1'b0;
  bit                 pend = 1'b0;
  int                 pend_cnt = 0;
  int                 pend_state = 0;
  logic [STATE_W-1:0] next_tab [64];
  bit                 bug_tab  [64];

  function automatic int f_next(input int s);
    case (mode)
      0:       return (s + 1 > 5) ? 5 : s + 1;
      1, 2:    return (s + 1) % 64;
      default: return int'(next_tab[s]);
    endcase
  endfunction

  function automatic bit f_bug(input int s);
    case (mode)
      1:       return (s == 3);
      3:       return bug_tab[s];
      default: return 1'b0;
    endcase
  endfunction

  // Inputs change on the falling edge so the DUT sees them settled at the rising edge.
  always @(negedge clk) begin
    ev_rsp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend         = 1'b0;
        ev_rsp_valid = 1'b1;
        ev_rsp_next  = STATE_W'(f_next(pend_state));
        ev_rsp_bug   = f_bug(pend_state);
      end
    end
    ev_req_ready = 1'b1;
    if (ev_req_valid && !rst) begin
      if (stall_left > 0) begin
        ev_req_ready = 1'b0;
        stall_left--;
      end else if (rand_ready && $urandom_range(0, 3) == 0) begin
        ev_req_ready = 1'b0;
      end
      if (ev_req_ready) begin
        pend       = 1'b1;
        pend_cnt   = rand_ready ? int'($urandom_range(1, 4)) : fixed_delay;
        pend_state = int'(ev_req_state);
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic ref_run(input int init, output int res, output int it, output int fin);
    int s;
    int nx;
    s   = init;
    res = RES_TMO;
    it  = 0;
    fin = init;
    for (int n = 1; n <= MAX_ITER; n++) begin
      nx = int'(next_tab[s]);
      it  = n;
      fin = s;
      if (bug_tab[s]) begin
        res = RES_BUG;
        return;
      end
      if (nx == s) begin
        res = RES_FIX;
        return;
      end
      if (n == MAX_ITER) begin
        res = RES_TMO;
        return;
      end
      s = nx;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int mode;
    int init;
    int stall;     // ready held low for this many ISSUE cycles on the first request
    int delay;     // response latency after acceptance
    int abort_at;  // falling-edge index after start at which abort is raised (-1 none)
    int pulse;     // re-pulse start while busy
    int res;
    int iter;      // -1: not checked
    int fin;
    int cycles;    // falling edges after the start edge until done is seen
  } vec_t;

  vec_t vecs [13];

  task automatic wait_done(input int limit, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < limit) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else cyc++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    cyc;
    bit    got;
    int    unstable;
    int    late_req;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    mode        = v.mode;
    stall_left  = v.stall;
    fixed_delay = v.delay;
    rand_ready  = 1'b0;
    start       = 1'b1;
    init_state  = STATE_W'(v.init);
    cyc = 0;
    got = 1'b0;
    unstable = 0;
    late_req = 0;
    while (!got && cyc < 1000) begin
      @(negedge clk);
      start = (v.pulse != 0 && cyc == 1);
      if (start) init_state = STATE_W'(v.init) ^ 6'h2A;
      abort = (cyc == v.abort_at);
      if (v.abort_at >= 0 && cyc > v.abort_at && ev_req_valid) late_req++;
      if (cyc <= v.stall && int'(ev_req_state) != v.init) unstable++;
      if (done) got = 1'b1;
      else cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    check({p, ".done_seen"}, int'(got), 1);
    check({p, ".cycles"}, cyc, v.cycles);
    check({p, ".result"}, int'(result), v.res);
    if (v.iter >= 0) check({p, ".iter_count"}, int'(iter_count), v.iter);
    check({p, ".final_state"}, int'(final_state), v.fin);
    if (v.stall > 0) check({p, ".req_state_stable"}, unstable, 0);
    if (v.abort_at >= 0) check({p, ".no_req_after_abort"}, late_req, 0);
    @(negedge clk);
    check({p, ".done_one_cycle"}, int'(done), 0);
    check({p, ".idle_after_done"}, int'(busy), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int bad;
    int cyc;
    bit got;
    int e_res;
    int e_it;
    int e_fin;
    int init;

    //              mode init stall dly abort pulse res      iter fin cycles
    vecs[0]  = '{0,   0,   0,   1,  -1,   0,   RES_FIX, 6,   5,  18};   // done in 19th cycle
    vecs[1]  = '{1,   0,   0,   1,  -1,   0,   RES_BUG, 4,   3,  12};
    vecs[2]  = '{2,   0,   0,   1,  -1,   0,   RES_TMO, 64,  63, 192};
    vecs[3]  = '{0,   0,   0,   5,   1,   0,   RES_ABT, 0,   0,  6};    // abort in WAIT, drain
    vecs[4]  = '{0,   0,   4,   1,  -1,   1,   RES_FIX, 6,   5,  22};
    vecs[5]  = '{0,   5,   0,   1,  -1,   0,   RES_FIX, 1,   5,  3};
    vecs[6]  = '{0,   7,   0,   1,  -1,   0,   RES_FIX, 2,   5,  6};
    vecs[7]  = '{1,   4,   0,   1,  -1,   0,   RES_BUG, 64,  3,  192};  // bug beats bound
    vecs[8]  = '{0,   0,   3,   1,   1,   0,   RES_ABT, 0,   0,  2};    // abort, ready low
    vecs[9]  = '{0,   0,   0,   3,   0,   0,   RES_ABT, 0,   0,  4};    // abort with handshake
    vecs[10] = '{0,   5,   0,   1,   2,   0,   RES_FIX, 1,   5,  3};    // fixpoint beats abort
    vecs[11] = '{0,   0,   0,   1,   2,   0,   RES_ABT, 1,   0,  3};    // abort in CHECK
    vecs[12] = '{0,   9,   0,   1,   1,   0,   RES_ABT, -1,  9,  2};    // abort with response

    // Power-on reset
    #1 rst = 1'b1;
    #1;
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.result", int'(result), 0);
    check("reset.iter_count", int'(iter_count), 0);
    check("reset.req_valid", int'(ev_req_valid), 0);
    check("reset.req_state", int'(ev_req_state), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Abort in IDLE does nothing
    bad = 0;
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bad += int'(busy) + int'(done);
    end
    abort = 1'b0;
    check("idle_abort_ignored", bad, 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Asynchronous reset in WAIT, away from any clock edge
    @(negedge clk);
    mode = 0;
    stall_left = 0;
    fixed_delay = 5;
    start = 1'b1;
    init_state = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_mid.in_wait", int'(busy && !ev_req_valid), 1);
    #2 rst = 1'b1;
    pend = 1'b0;
    #1;
    check("rst_mid.busy", int'(busy), 0);
    check("rst_mid.req_valid", int'(ev_req_valid), 0);
    check("rst_mid.result", int'(result), 0);
    check("rst_mid.done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid.idle_after", int'(busy), 0);
    run_vec(100, vecs[0]);

    // Randomized runs against the iteration model
    for (int r = 0; r < 24; r++) begin
      for (int s = 0; s < 64; s++) begin
        next_tab[s] = ($urandom_range(0, 11) == 0) ? STATE_W'(s) : STATE_W'($urandom_range(0, 63));
        bug_tab[s]  = ($urandom_range(0, 39) == 0);
      end
      if (r % 6 == 5) begin
        for (int s = 0; s < 64; s++) begin
          next_tab[s] = STATE_W'((s + 7) % 64);
          bug_tab[s]  = 1'b0;
        end
      end
      init = int'($urandom_range(0, 63));
      ref_run(init, e_res, e_it, e_fin);
      @(negedge clk);
      mode = 3;
      stall_left = 0;
      rand_ready = 1'b1;
      start = 1'b1;
      init_state = STATE_W'(init);
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
      else wait_done(5000, got, cyc);
      check($sformatf("rnd%0d.done_seen", r), int'(got), 1);
      check($sformatf("rnd%0d.result", r), int'(result), e_res);
      check($sformatf("rnd%0d.iter_count", r), int'(iter_count), e_it);
      check($sformatf("rnd%0d.final_state", r), int'(final_state), e_fin);
      @(negedge clk);
      check($sformatf("rnd%0d.done_one_cycle", r), int'(done), 0);
    end
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
